// File: rtl/mealy_pkg.sv
// rtl/mealy_pkg.sv - shared 2-bit Mealy pattern-detector types and transition functions
package mealy_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ONE  = 2'b01,
    S_TWO  = 2'b11,
    S_RUN  = 2'b10
  } state_t;

  // Next state: a zero always returns to idle; ones walk idle->one->two->run and stay in run.
  function automatic state_t mealy_next(input state_t s, input logic b);
    state_t n;
    if (!b) begin
      n = S_IDLE;
    end else begin
      case (s)
        S_IDLE:  n = S_ONE;
        S_ONE:   n = S_TWO;
        S_TWO:   n = S_RUN;
        default: n = S_RUN;
      endcase
    end
    return n;
  endfunction

  // Detection fires on a zero that terminates a run of one or more ones.
  function automatic logic mealy_out(input state_t s, input logic b);
    return ~b & (s != S_IDLE);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot arbiter with its own last-grant pointer
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int CW  = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] req,
  output logic [NCH-1:0] gnt
);

  logic [CW-1:0] last_grant;
  logic [CW-1:0] gidx;
  logic [CW-1:0] pos;
  logic          found;

  // Scan requesters starting just after the last winner; first hit wins.
  always_comb begin
    gnt   = '0;
    gidx  = '0;
    pos   = '0;
    found = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      pos = CW'((int'(last_grant) + k) % NCH);
      if (!found && req[pos]) begin
        found     = 1'b1;
        gnt[pos]  = 1'b1;
        gidx      = pos;
      end
    end
    if (reset) begin
      gnt = '0;
    end
  end

  // Pointer moves only when something was granted; reset parks it so channel 0 leads.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= CW'(NCH - 1);
    end else if (found) begin
      last_grant <= gidx;
    end
  end

endmodule

// File: rtl/mealy_ctx_scheduler.sv
// rtl/mealy_ctx_scheduler.sv - one shared Mealy detector time-sliced across NCH bit streams
module mealy_ctx_scheduler
  import mealy_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int CW   = $clog2(NCH),
  parameter int CNTW = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCH-1:0]      req_valid,
  input  logic [NCH-1:0]      req_bit,
  input  logic [NCH-1:0]      clr_ch,
  output logic [NCH-1:0]      grant,
  output logic                hit_valid,
  output logic [CW-1:0]       hit_ch,
  output logic [NCH*2-1:0]    state_flat,
  output logic [NCH*CNTW-1:0] cnt_flat
);

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  state_t          ctx   [NCH];
  state_t          ctx_d [NCH];
  logic [CNTW-1:0] cnt   [NCH];
  logic [CNTW-1:0] cnt_d [NCH];

  logic [NCH-1:0]  elig;
  logic [CW-1:0]   gidx;
  logic            any_gnt;
  state_t          sel_s;
  logic            sel_b;
  state_t          sel_next;
  logic            sel_out;

  // A channel being cleared sits out this cycle so the clear never races its bit.
  assign elig = req_valid & ~clr_ch;

  rr_arbiter #(.NCH(NCH), .CW(CW)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (elig),
    .gnt   (grant)
  );

  // Encode the one-hot grant and route the winner's context through the shared detector.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) gidx = CW'(i);
    end
    any_gnt  = |grant;
    sel_s    = ctx[gidx];
    sel_b    = req_bit[gidx];
    sel_next = mealy_next(sel_s, sel_b);
    sel_out  = mealy_out(sel_s, sel_b);
  end

  // Next contexts/counters: clear wins, otherwise only the granted channel advances.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ctx_d[i] = ctx[i];
      cnt_d[i] = cnt[i];
      if (clr_ch[i]) begin
        ctx_d[i] = S_IDLE;
        cnt_d[i] = '0;
      end else if (grant[i]) begin
        ctx_d[i] = sel_next;
        if (sel_out && cnt[i] != CNT_MAX) cnt_d[i] = cnt[i] + 1'b1;
      end
    end
  end

  // Context/counter store and the one-cycle hit register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        ctx[i] <= S_IDLE;
        cnt[i] <= '0;
      end
      hit_valid <= 1'b0;
      hit_ch    <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        ctx[i] <= ctx_d[i];
        cnt[i] <= cnt_d[i];
      end
      hit_valid <= any_gnt & sel_out;
      if (any_gnt) hit_ch <= gidx;
    end
  end

  // Flatten the per-channel arrays onto the status buses.
  always_comb begin
    state_flat = '0;
    cnt_flat   = '0;
    for (int i = 0; i < NCH; i++) begin
      state_flat[2*i +: 2]     = ctx[i];
      cnt_flat[CNTW*i +: CNTW] = cnt[i];
    end
  end

endmodule
